// File: rtl/bcd_timer_ctrl.sv
// Stopwatch / countdown sequencer for a chain of NDIG cascaded BCD digits.
// Optional lap capture is built when BCD_TIMER_LAP_EN is defined.
module bcd_timer_ctrl #(
    parameter int NDIG     = 4,
    parameter int PRESCALE = 100000,
    parameter int PW       = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic              load,
    input  logic [4*NDIG-1:0] preset,
    input  logic              mode,
`ifdef BCD_TIMER_LAP_EN
    input  logic              lap,
    output logic [4*NDIG-1:0] lap_digits,
    output logic              lap_valid,
`endif
    output logic [4*NDIG-1:0] digits,
    output logic [1:0]        state,
    output logic              running,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    state_t            state_q, state_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [4*NDIG-1:0] digits_q, digits_d;
    logic              running_q, done_q, done_d;

    logic [4*NDIG-1:0] stepped, preset_clean;
    logic              at_term, stepped_term, en;
    logic [3:0]        term_digit;

    // Valid/ready does not apply here: every command is a one-cycle pulse,
    // acted on the edge it is sampled, priority clear > load > stop > start.

    // Carry/borrow ripple: digit i moves only when all lower digits sit at
    // the wrap value for the current direction.
    always_comb begin
        stepped      = digits_q;
        preset_clean = '0;
        at_term      = 1'b1;
        stepped_term = 1'b1;
        en           = 1'b1;
        term_digit   = mode ? 4'd9 : 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (en) begin
                if (mode)
                    stepped[4*i +: 4] = (digits_q[4*i +: 4] == 4'd9) ? 4'd0 : digits_q[4*i +: 4] + 4'd1;
                else
                    stepped[4*i +: 4] = (digits_q[4*i +: 4] == 4'd0) ? 4'd9 : digits_q[4*i +: 4] - 4'd1;
            end
            en      = en & (digits_q[4*i +: 4] == term_digit);
            at_term = at_term & (digits_q[4*i +: 4] == term_digit);
            preset_clean[4*i +: 4] = (preset[4*i +: 4] > 4'd9) ? 4'd9 : preset[4*i +: 4];
        end
        for (int i = 0; i < NDIG; i++)
            stepped_term = stepped_term & (stepped[4*i +: 4] == term_digit);
    end

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        presc_d  = presc_q;
        done_d   = 1'b0;
        if (clear) begin
            state_d  = S_IDLE;
            digits_d = '0;
            presc_d  = '0;
        end else if (load && state_q != S_RUN) begin
            digits_d = preset_clean;
            state_d  = (state_q == S_PAUSE) ? S_PAUSE : S_IDLE;
        end else if (stop && state_q == S_RUN) begin
            state_d = S_PAUSE;
        end else if (start && state_q == S_IDLE) begin
            presc_d = '0;
            if (at_term) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end else begin
                state_d = S_RUN;
            end
        end else if (start && state_q == S_PAUSE) begin
            // Resume keeps the retained prescaler phase.
            state_d = S_RUN;
        end else if (state_q == S_RUN) begin
            if (presc_q == PRESC_LAST) begin
                presc_d  = '0;
                digits_d = stepped;
                if (stepped_term) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            digits_q  <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            digits_q  <= digits_d;
            running_q <= (state_d == S_RUN);
            done_q    <= done_d;
        end
    end

`ifdef BCD_TIMER_LAP_EN
    logic [4*NDIG-1:0] lap_digits_q;
    logic              lap_valid_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lap_digits_q <= '0;
            lap_valid_q  <= 1'b0;
        end else if (lap && state_q == S_RUN) begin
            lap_digits_q <= digits_q;
            lap_valid_q  <= 1'b1;
        end
    end

    assign lap_digits = lap_digits_q;
    assign lap_valid  = lap_valid_q;
`endif

    assign digits  = digits_q;
    assign state   = state_q;
    assign running = running_q;
    assign done    = done_q;

endmodule
